// File: rtl/select_validate_responder.sv
// select_validate_responder: device-side SelectTest/Validate test-control responder.
// Ports:
//   clk, rst        - single rising-edge clock, synchronous active-high reset
//   SelectTest      - one-cycle strobe that starts a test (accepted only in IDLE)
//   test_id         - test ID, latched when SelectTest is accepted
//   Validate        - level input; only a rising edge seen in ARMED starts counting
//   busy, armed     - phase indicators (busy: SELECT/VALIDATE/DONE, armed: ARMED)
//   log_valid/data  - periodic log strobe carrying the current count
//   done, done_id   - one-cycle completion pulse with the latched test ID
//   pass            - self-check result, valid with done
//   proto_err       - sticky ignored-event flag, present only with SV_RESP_PROTO_CHECK_EN
module select_validate_responder #(
    parameter int CNT_W         = 12,
    parameter int LOG_SHIFT     = 4,
    parameter int SELECT_CYCLES = 8,
    parameter int ID_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SelectTest,
    input  logic [ID_W-1:0]  test_id,
    input  logic             Validate,
    output logic             busy,
    output logic             armed,
    output logic             log_valid,
    output logic [CNT_W-1:0] log_data,
    output logic             done,
    output logic [ID_W-1:0]  done_id,
    output logic             pass
`ifdef SV_RESP_PROTO_CHECK_EN
   ,output logic             proto_err
`endif
);
    localparam int SEL_W = $clog2(SELECT_CYCLES + 1);
    localparam int LOG_W = CNT_W - LOG_SHIFT + 1;
    localparam logic [LOG_W-1:0] LOG_TOTAL = LOG_W'(2 ** (CNT_W - LOG_SHIFT));

    typedef enum logic [2:0] {IDLE, SELECT, ARMED, VALIDATE, DONE} state_t;

    state_t           state_q, state_d;
    logic             validate_q;
    logic [SEL_W-1:0] sel_cnt;
    logic [CNT_W-1:0] cnt;
    logic [LOG_W-1:0] log_cnt;
    logic [ID_W-1:0]  id_q;
    logic             v_edge;

    assign v_edge = Validate & ~validate_q;

    always_ff @(posedge clk)
        state_q <= rst ? IDLE : state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = SelectTest ? SELECT : IDLE;
            SELECT:   state_d = (sel_cnt == '0) ? ARMED : SELECT;
            ARMED:    state_d = v_edge ? VALIDATE : ARMED;
            VALIDATE: state_d = (&cnt) ? DONE : VALIDATE;
            default:  state_d = IDLE;
        endcase
    end

    // Outputs depend on registered state only.
    always_comb begin
        busy      = (state_q == SELECT) || (state_q == VALIDATE) || (state_q == DONE);
        armed     = state_q == ARMED;
        log_valid = (state_q == VALIDATE) && (cnt[LOG_SHIFT-1:0] == LOG_SHIFT'(1));
        log_data  = cnt;
        done      = state_q == DONE;
        done_id   = id_q;
        pass      = done && (log_cnt == LOG_TOTAL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            validate_q <= 1'b0;
            sel_cnt    <= '0;
            cnt        <= '0;
            log_cnt    <= '0;
            id_q       <= '0;
        end else begin
            validate_q <= Validate;
            if (state_q == IDLE && SelectTest) begin
                id_q    <= test_id;
                sel_cnt <= SEL_W'(SELECT_CYCLES - 1);
            end
            if (state_q == SELECT && sel_cnt != '0)
                sel_cnt <= sel_cnt - 1'b1;
            if (state_q == ARMED && v_edge) begin
                cnt     <= CNT_W'(1);
                log_cnt <= '0;
            end
            if (state_q == VALIDATE) begin
                cnt <= cnt + 1'b1;
                if (log_valid)
                    log_cnt <= log_cnt + 1'b1;
            end
        end
    end

`ifdef SV_RESP_PROTO_CHECK_EN
    // Flags SelectTest outside IDLE and any Validate edge outside ARMED,
    // which also covers a Validate edge coinciding with SelectTest in IDLE.
    always_ff @(posedge clk) begin
        if (rst)
            proto_err <= 1'b0;
        else if ((SelectTest && state_q != IDLE) || (v_edge && state_q != ARMED))
            proto_err <= 1'b1;
    end
`else
`endif

endmodule
